sd_spi_master: RTL and testbench

SD_SPI_MASTER -- requirements
Module: sd_spi_master

---
 rtl/sd_spi_pkg.sv | 17 +
 rtl/sd_spi_master_clkdiv.sv | 27 ++
 rtl/sd_spi_master.sv | 164 ++++++++++++++++
 tb/tb_sd_spi_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master.
package sd_spi_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } spi_state_e;

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic bit_in);
    return {sh[6:0], bit_in};
  endfunction

endpackage

// File: rtl/sd_spi_master_clkdiv.sv
// SCK half-period counter: restarts on load, ticks at div_lat and reloads on every tick.
module sd_spi_clkdiv
  import sd_spi_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div_lat,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = (cnt_r == div_lat);

  // Half-period count, restarted by a transfer start or a phase change
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (load || tick) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for SD cards with a write-buffered chip-select register.
// Build option: SD_SPI_LATE_SAMPLE_EN moves the MISO capture to the last clk_sys cycle of SCK high.
module sd_spi_master
  import sd_spi_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic [DIV_W-1:0] div,
  input  logic             cs_we,
  input  logic             cs_val,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_byte,
  output logic             sd_cs0_n_o,
  output logic             sd_sclk_o,
  output logic             sd_mosi_o,
  input  logic             sd_miso_i
);

  spi_state_e       state_r;
  logic [7:0]       tx_sh_r;
  logic [7:0]       rx_sh_r;
  logic [7:0]       rx_r;
  logic [2:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic             busy_r;
  logic             done_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             cs_n_r;
  logic             pend_r;
  logic             pend_val_r;
  logic             accept_s;
  logic             tick_s;
  logic [7:0]       rx_cap_s;

  // A new byte may only be accepted while no byte is on the wire
  always_comb begin
    accept_s = 1'b0;
    if (start && ((state_r == IDLE) || (state_r == FINISH))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Receive shift register with the current MISO bit appended
  always_comb begin
    rx_cap_s = shift_in(rx_sh_r, sd_miso_i);
  end

  sd_spi_clkdiv u_clkdiv (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .load    (accept_s),
    .div_lat (div_r),
    .tick    (tick_s)
  );

  // Transfer sequencer; all outputs are registered here
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      tx_sh_r    <= 8'h00;
      rx_sh_r    <= 8'h00;
      rx_r       <= 8'h00;
      bit_cnt_r  <= 3'd0;
      div_r      <= {DIV_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b1;
      cs_n_r     <= 1'b1;
      pend_r     <= 1'b0;
      pend_val_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, FINISH: begin
          if (cs_we) begin
            cs_n_r <= ~cs_val;
          end
          if (start) begin
            state_r   <= SHIFT_LO;
            tx_sh_r   <= tx_byte;
            div_r     <= div;
            mosi_r    <= tx_byte[7];
            bit_cnt_r <= 3'd0;
            busy_r    <= 1'b1;
          end else begin
            state_r <= IDLE;
            mosi_r  <= 1'b1;
          end
        end
        SHIFT_LO: begin
          if (cs_we) begin
            pend_r     <= 1'b1;
            pend_val_r <= cs_val;
          end
          if (tick_s) begin
            state_r <= SHIFT_HI;
            sclk_r  <= 1'b1;
`ifndef SD_SPI_LATE_SAMPLE_EN
            rx_sh_r <= rx_cap_s;
`endif
          end
        end
        SHIFT_HI: begin
          if (tick_s && (bit_cnt_r == 3'd7)) begin
            // Last bit: close the byte and release any buffered chip-select write
            state_r <= FINISH;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            mosi_r  <= 1'b1;
`ifdef SD_SPI_LATE_SAMPLE_EN
            rx_sh_r <= rx_cap_s;
            rx_r    <= rx_cap_s;
`else
            rx_r    <= rx_sh_r;
`endif
            if (cs_we) begin
              cs_n_r <= ~cs_val;
            end else if (pend_r) begin
              cs_n_r <= ~pend_val_r;
            end
            pend_r <= 1'b0;
          end else begin
            if (cs_we) begin
              pend_r     <= 1'b1;
              pend_val_r <= cs_val;
            end
            if (tick_s) begin
              state_r   <= SHIFT_LO;
              sclk_r    <= 1'b0;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_sh_r   <= {tx_sh_r[6:0], 1'b0};
              mosi_r    <= tx_sh_r[6];
`ifdef SD_SPI_LATE_SAMPLE_EN
              rx_sh_r   <= rx_cap_s;
`endif
            end
          end
        end
        default: begin
          state_r <= IDLE;
          sclk_r  <= 1'b0;
          busy_r  <= 1'b0;
          mosi_r  <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign rx_byte    = rx_r;
  assign sd_cs0_n_o = cs_n_r;
  assign sd_sclk_o  = sclk_r;
  assign sd_mosi_o  = mosi_r;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: timing, data, chip-select buffering, reset abort, late sampling.
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_byte;
  logic [7:0] div;
  logic       cs_we;
  logic       cs_val;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       sd_cs0_n_o;
  logic       sd_sclk_o;
  logic       sd_mosi_o;
  logic       sd_miso_i;

  // card model: mode 0 shifts after SCK fall, mode 1 shifts one cycle after SCK rise
  logic       loop_mode;
  logic       card_mode;
  logic       card_ld;
  logic [8:0] card_ld_val;
  logic [8:0] card_sh;
  logic       sclk_d;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rises, highs, busy_lo, n;
  logic [7:0] mosi_cap;
  logic       csn_before;
  logic [7:0] exp_late;

  always #5 clk_sys = ~clk_sys;

  sd_spi_master dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .start      (start),
    .tx_byte    (tx_byte),
    .div        (div),
    .cs_we      (cs_we),
    .cs_val     (cs_val),
    .busy       (busy),
    .done       (done),
    .rx_byte    (rx_byte),
    .sd_cs0_n_o (sd_cs0_n_o),
    .sd_sclk_o  (sd_sclk_o),
    .sd_mosi_o  (sd_mosi_o),
    .sd_miso_i  (sd_miso_i)
  );

  assign sd_miso_i = loop_mode ? sd_mosi_o : card_sh[8];

  always @(posedge clk_sys) begin
    sclk_d <= sd_sclk_o;
    if (card_ld) card_sh <= card_ld_val;
    else if (!card_mode && sclk_d && !sd_sclk_o) card_sh <= {card_sh[7:0], 1'b1};
    else if (card_mode && !sclk_d && sd_sclk_o) card_sh <= {card_sh[7:0], 1'b1};
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_xfer(input logic [7:0] d, input logic [7:0] t);
    div = d; tx_byte = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_card(input logic m, input logic [8:0] v);
    card_mode = m; card_ld_val = v; card_ld = 1'b1;
    tick();
    card_ld = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cnt);
    logic prev_sclk;
    prev_sclk = sd_sclk_o;
    rises = 0; highs = 0; busy_lo = 0; mosi_cap = 8'h00;
    csn_before = sd_cs0_n_o;
    cnt = -1;
    for (int i = 1; i <= budget; i++) begin
      csn_before = sd_cs0_n_o;
      tick();
      if (sd_sclk_o) highs++;
      if (sd_sclk_o && !prev_sclk) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], sd_mosi_o};
      end
      if (!busy) busy_lo++;
      prev_sclk = sd_sclk_o;
      if (done) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; tx_byte = 8'h00; div = 8'h00;
    cs_we = 1'b0; cs_val = 1'b0; loop_mode = 1'b1;
    card_mode = 1'b0; card_ld = 1'b0; card_ld_val = 9'h1FF;
    tick(); tick();
    chk("reset_outputs", {19'd0, sd_sclk_o, sd_mosi_o, sd_cs0_n_o, busy, done, rx_byte},
        {19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    reset_n = 1'b1;
    tick();

    // div=0, loopback A5
    start_xfer(8'd0, 8'hA5);
    chk("s1_busy_mosi", {30'd0, busy, sd_mosi_o}, {30'd0, 1'b1, 1'b1});
    wait_done(200, n);
    chk("s1_latency", n, 32'd16);
    chk("s1_sck_rises", rises, 32'd8);
    chk("s1_sck_high_cycles", highs, 32'd8);
    chk("s1_rx", {24'd0, rx_byte}, {24'd0, 8'hA5});
    chk("s1_finish_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("s1_done_one_cycle", {31'd0, done}, 32'd0);

    // div=3, card returns 01
    loop_mode = 1'b0;
    load_card(1'b0, {8'h01, 1'b1});
    start_xfer(8'd3, 8'h40);
    wait_done(200, n);
    chk("s2_latency", n, 32'd64);
    chk("s2_mosi_pattern", {24'd0, mosi_cap}, {24'd0, 8'h40});
    chk("s2_rx", {24'd0, rx_byte}, {24'd0, 8'h01});
    tick();

    // back-to-back: start in FINISH
    loop_mode = 1'b1;
    start_xfer(8'd0, 8'h5A);
    wait_done(200, n);
    chk("s3_first_latency", n, 32'd16);
    chk("s3_first_rx", {24'd0, rx_byte}, {24'd0, 8'h5A});
    start_xfer(8'd0, 8'hFF);
    chk("s3_no_idle_gap", {29'd0, busy, sd_sclk_o, done}, {29'd0, 1'b1, 1'b0, 1'b0});
    wait_done(200, n);
    chk("s3_second_latency", n, 32'd16);
    chk("s3_busy_low_only_finish", busy_lo, 32'd1);
    chk("s3_second_rx", {24'd0, rx_byte}, {24'd0, 8'hFF});
    tick();

    // chip select buffered while busy; start during busy ignored
    cs_we = 1'b1; cs_val = 1'b1;
    tick();
    cs_we = 1'b0;
    chk("s4_cs_select_idle", {31'd0, sd_cs0_n_o}, 32'd0);
    start_xfer(8'd1, 8'h3C);
    repeat (12) tick();
    cs_we = 1'b1; cs_val = 1'b0; start = 1'b1; tx_byte = 8'h00;
    tick();
    cs_we = 1'b0; start = 1'b0;
    chk("s4_cs_held_busy", {31'd0, sd_cs0_n_o}, 32'd0);
    wait_done(200, n);
    chk("s4_latency_unchanged", n, 32'd19);
    chk("s4_cs_before_finish", {31'd0, csn_before}, 32'd0);
    chk("s4_cs_in_finish", {31'd0, sd_cs0_n_o}, 32'd1);
    chk("s4_rx_start_ignored", {24'd0, rx_byte}, {24'd0, 8'h3C});
    tick();
    chk("s4_idle_after", {31'd0, busy}, 32'd0);

    // cs_we with start in IDLE, then reset at bit 5
    div = 8'd1; tx_byte = 8'hC3; start = 1'b1; cs_we = 1'b1; cs_val = 1'b1;
    tick();
    start = 1'b0; cs_we = 1'b0;
    chk("s5_cs_with_start", {30'd0, sd_cs0_n_o, busy}, {30'd0, 1'b0, 1'b1});
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    chk("s5_reset_outputs", {19'd0, sd_sclk_o, sd_mosi_o, sd_cs0_n_o, busy, done, rx_byte},
        {19'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) n++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n++;
    end
    chk("s5_no_done", n, 32'd0);
    start_xfer(8'd0, 8'h96);
    wait_done(200, n);
    chk("s5_after_latency", n, 32'd16);
    chk("s5_after_rx", {24'd0, rx_byte}, {24'd0, 8'h96});
    tick();

    // card answers one cycle after SCK rise
`ifdef SD_SPI_LATE_SAMPLE_EN
    exp_late = 8'h3C;
`else
    exp_late = 8'h9E;
`endif
    loop_mode = 1'b0;
    load_card(1'b1, {1'b1, 8'h3C});
    start_xfer(8'd2, 8'h00);
    wait_done(300, n);
    chk("s6_latency", n, 32'd48);
    chk("s6_rx_delayed_card", {24'd0, rx_byte}, {24'd0, exp_late});
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
